// File: rtl/demux_seq_pkg.sv
// Shared definitions for the demux slot sequencer: default widths and FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package demux_seq_pkg;

  localparam int NSEL_DEF = 4;
  localparam int NCH_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/demux_next_sel.sv
// Finds the next enabled channel strictly above a pointer (or the lowest one when i_first).
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle.
// Ports: i_en enable set, i_ptr current channel, i_first treats the pointer as -1,
//        o_next next enabled index, o_last high when nothing enabled lies above the pointer.
module demux_next_sel
  import demux_seq_pkg::*;
#(
  parameter  int NSEL = NSEL_DEF,
  localparam int NCH  = 2**NSEL
) (
  input  logic [NCH-1:0]  i_en,
  input  logic [NSEL-1:0] i_ptr,
  input  logic            i_first,
  output logic [NSEL-1:0] o_next,
  output logic            o_last
);

  logic w_found;

  // Scan downwards so the final match written is the lowest qualifying index.
  always_comb begin
    o_next  = '0;
    w_found = 1'b0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (i_en[k] && (i_first || (k > int'(i_ptr)))) begin
        o_next  = NSEL'(k);
        w_found = 1'b1;
      end
    end
  end

  assign o_last = ~w_found;

endmodule

// File: rtl/demux_slot_sequencer.sv
// Walks a 16-way demux select through one frame, pairing each accepted serial bit with its channel.
// Latency: handshake at t gives S/OUT/OUT_VLD at t+1; START at t gives RUN (IN_READY) at t+1.
// Backpressure: IN_READY is high for the whole of RUN; IN_VALID low simply holds the channel pointer.
// Ports: CLK, RST_N (async active-low), START, IN_VALID/IN_DATA/IN_READY upstream handshake,
//        MASK channel enables (only with DEMUX_SEQ_CH_MASK_EN), S/OUT/OUT_VLD demux drive,
//        FRAME_DONE end-of-frame pulse, BUSY high in RUN and DONE.
// Build option: define DEMUX_SEQ_CH_MASK_EN to add the MASK port; otherwise every channel is enabled.
module demux_slot_sequencer
  import demux_seq_pkg::*;
#(
  parameter  int NSEL = NSEL_DEF,
  localparam int NCH  = 2**NSEL
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            START,
  input  logic            IN_VALID,
  input  logic            IN_DATA,
  output logic            IN_READY,
`ifdef DEMUX_SEQ_CH_MASK_EN
  input  logic [NCH-1:0]  MASK,
`endif
  output logic [NSEL-1:0] S,
  output logic            OUT,
  output logic            OUT_VLD,
  output logic            FRAME_DONE,
  output logic            BUSY
);

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_armed;
  logic [NCH-1:0]  r_en;
  logic [NCH-1:0]  w_mask;
  logic [NSEL-1:0] r_ptr;
  logic [NSEL-1:0] r_s;
  logic            r_out;
  logic            r_out_vld;
  logic [NSEL-1:0] w_first_idx;
  logic [NSEL-1:0] w_next_idx;
  logic            w_empty;
  logic            w_last;
  logic            w_start_ok;
  logic            w_hs;

`ifdef DEMUX_SEQ_CH_MASK_EN
  assign w_mask = MASK;
`else
  assign w_mask = '1;
`endif

  // r_armed is still 0 on the first edge after reset release, so a START
  // overlapping the release is not taken.
  assign w_start_ok = START & r_armed & (r_state == ST_IDLE);
  assign w_hs       = IN_VALID & (r_state == ST_RUN);

  demux_next_sel #(.NSEL(NSEL)) u_first (
    .i_en    (w_mask),
    .i_ptr   ('0),
    .i_first (1'b1),
    .o_next  (w_first_idx),
    .o_last  (w_empty)
  );

  demux_next_sel #(.NSEL(NSEL)) u_next (
    .i_en    (r_en),
    .i_ptr   (r_ptr),
    .i_first (1'b0),
    .o_next  (w_next_idx),
    .o_last  (w_last)
  );

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start_ok) w_state_nxt = w_empty ? ST_DONE : ST_RUN;
      ST_RUN:  if (w_hs && w_last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    IN_READY   = (r_state == ST_RUN);
    BUSY       = (r_state == ST_RUN) || (r_state == ST_DONE);
    FRAME_DONE = (r_state == ST_DONE);
  end

  // Pointer, captured enable set and the registered demux drive
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_armed   <= 1'b0;
      r_en      <= '0;
      r_ptr     <= '0;
      r_s       <= '0;
      r_out     <= 1'b0;
      r_out_vld <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      if (w_start_ok) begin
        r_en  <= w_mask;
        r_ptr <= w_first_idx;
      end else if (w_hs && !w_last) begin
        r_ptr <= w_next_idx;
      end
      // OUT is forced low off-strobe so no demux leg sees stale data; S holds.
      if (w_hs) begin
        r_s       <= r_ptr;
        r_out     <= IN_DATA;
        r_out_vld <= 1'b1;
      end else begin
        r_out     <= 1'b0;
        r_out_vld <= 1'b0;
      end
    end
  end

  assign S       = r_s;
  assign OUT     = r_out;
  assign OUT_VLD = r_out_vld;

endmodule

// File: tb/tb_demux_slot_sequencer.sv
// Randomised scoreboard bench for demux_slot_sequencer: frame model pushes expected strobes, a monitor pops them.
// Latency: expectations are compared on the negedge following each accepted bit.
// Backpressure: IN_VALID gaps are injected both at fixed points and at random.
module tb_demux_slot_sequencer;

  localparam int NSEL = 4;
  localparam int NCH  = 16;

  logic            CLK = 1'b0;
  logic            RST_N;
  logic            START;
  logic            IN_VALID;
  logic            IN_DATA;
  logic            IN_READY;
  logic [NCH-1:0]  MASK;
  logic [NSEL-1:0] S;
  logic            OUT;
  logic            OUT_VLD;
  logic            FRAME_DONE;
  logic            BUSY;

  typedef struct {
    int ch;
    bit d;
    bit last;
    bit empty;
  } exp_t;

  exp_t q[$];
  int   frame_ch[$];
  int   hs_idx  = 0;
  int   checks  = 0;
  int   errors  = 0;
  int   hold_s  = 0;
  bit   in_run  = 1'b0;

  demux_slot_sequencer #(.NSEL(NSEL)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .START      (START),
    .IN_VALID   (IN_VALID),
    .IN_DATA    (IN_DATA),
    .IN_READY   (IN_READY),
`ifdef DEMUX_SEQ_CH_MASK_EN
    .MASK       (MASK),
`endif
    .S          (S),
    .OUT        (OUT),
    .OUT_VLD    (OUT_VLD),
    .FRAME_DONE (FRAME_DONE),
    .BUSY       (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Frame contents: enabled channels in ascending order, one per handshake.
  task automatic build_frame(input logic [NCH-1:0] m);
    frame_ch.delete();
    for (int k = 0; k < NCH; k++)
      if (m[k]) frame_ch.push_back(k);
    hs_idx = 0;
  endtask

  // Monitor: every strobe or done pulse must match the head of the scoreboard.
  always @(negedge CLK) begin
    exp_t e;
    chk("in_ready", int'(IN_READY), int'(in_run));
    if (OUT_VLD || FRAME_DONE) begin
      if (q.size() == 0) begin
        chk("unexpected_strobe_vld_done", int'({OUT_VLD, FRAME_DONE}), 0);
      end else begin
        e = q.pop_front();
        chk("out_vld", int'(OUT_VLD), int'(!e.empty));
        chk("frame_done", int'(FRAME_DONE), int'(e.last || e.empty));
        if (!e.empty) begin
          chk("sel", int'(S), e.ch);
          chk("out_data", int'(OUT), int'(e.d));
          hold_s = e.ch;
        end
      end
    end else begin
      chk("gap_out_zero", int'(OUT), 0);
      chk("gap_s_hold", int'(S), hold_s);
    end
  end

  // Called at posedge+1; returns at posedge+1 with the DUT in RUN or back in IDLE.
  task automatic do_start(input logic [NCH-1:0] m);
    logic [NCH-1:0] eff;
`ifdef DEMUX_SEQ_CH_MASK_EN
    eff = m;
`else
    eff = '1;
`endif
    MASK = m;
    build_frame(eff);
    START    = 1'b1;
    IN_VALID = 1'b0;
    @(posedge CLK);
    if (frame_ch.size() == 0) begin
      exp_t e;
      e = '{ch: 0, d: 1'b0, last: 1'b0, empty: 1'b1};
      q.push_back(e);
    end else begin
      in_run = 1'b1;
    end
    #1;
    START = 1'b0;
    MASK  = 16'($urandom_range(65535));
    if (frame_ch.size() == 0) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic do_abort_reset();
    #2 RST_N = 1'b0;
    #1;
    q.delete();
    in_run   = 1'b0;
    hold_s   = 0;
    IN_VALID = 1'b0;
    START    = 1'b0;
    chk("abort_s", int'(S), 0);
    chk("abort_out", int'(OUT), 0);
    chk("abort_out_vld", int'(OUT_VLD), 0);
    chk("abort_frame_done", int'(FRAME_DONE), 0);
    chk("abort_in_ready", int'(IN_READY), 0);
    chk("abort_busy", int'(BUSY), 0);
    @(posedge CLK);
    @(posedge CLK);
    #1 RST_N = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic run_frame(input int gap_at, input int gap_len, input int rand_pct,
                           input bit start_mid, input bit start_in_done, input int abort_at);
    int nhs     = 0;
    int gap_cnt = 0;
    int budget  = 0;
    while (in_run) begin
      bit v;
      bit d;
      v = 1'b1;
      if (rand_pct > 0 && $urandom_range(99) < rand_pct) v = 1'b0;
      if (gap_at >= 0 && nhs == gap_at && gap_cnt < gap_len) begin
        v = 1'b0;
        gap_cnt++;
      end
      d        = 1'($urandom_range(1));
      IN_VALID = v;
      IN_DATA  = d;
      START    = start_mid && (nhs == 3);
      @(posedge CLK);
      if (v) begin
        exp_t e;
        e.ch    = frame_ch[hs_idx];
        e.d     = d;
        e.last  = (hs_idx == frame_ch.size() - 1);
        e.empty = 1'b0;
        q.push_back(e);
        hs_idx++;
        nhs++;
        if (e.last) in_run = 1'b0;
      end
      budget++;
      if (budget > 500) begin
        chk("frame_timeout_handshakes", nhs, frame_ch.size());
        in_run = 1'b0;
        break;
      end
      if (abort_at > 0 && v && nhs == abort_at) begin
        do_abort_reset();
        return;
      end
      #1;
    end
    // DONE cycle; optionally pulse START into it, which must be ignored.
    IN_VALID = 1'b0;
    START    = start_in_done;
    @(posedge CLK);
    #1;
    START = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    RST_N    = 1'b1;
    START    = 1'b0;
    IN_VALID = 1'b0;
    IN_DATA  = 1'b0;
    MASK     = '1;
    #2 RST_N = 1'b0;
    #1;
    chk("rst_s", int'(S), 0);
    chk("rst_out", int'(OUT), 0);
    chk("rst_out_vld", int'(OUT_VLD), 0);
    chk("rst_frame_done", int'(FRAME_DONE), 0);
    chk("rst_in_ready", int'(IN_READY), 0);
    chk("rst_busy", int'(BUSY), 0);
    repeat (2) @(posedge CLK);
    #1;

    // START coinciding with reset release is dropped.
    START = 1'b1;
    RST_N = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
    chk("start_at_release_busy", int'(BUSY), 0);

    // Full frame, continuous valid.
    do_start('1);
    chk("start_busy", int'(BUSY), 1);
    run_frame(-1, 0, 0, 1'b0, 1'b0, 0);

    // Three-cycle gap after the fifth bit.
    do_start('1);
    run_frame(5, 3, 0, 1'b0, 1'b0, 0);

    // START mid-frame and in DONE ignored; the following START restarts at 0.
    do_start('1);
    run_frame(-1, 0, 0, 1'b1, 1'b1, 0);
    do_start('1);
    chk("restart_busy", int'(BUSY), 1);
    run_frame(-1, 0, 20, 1'b0, 1'b0, 0);

    // Reset after seven handshakes, then a clean frame.
    do_start('1);
    run_frame(-1, 0, 0, 1'b0, 1'b0, 7);
    do_start('1);
    run_frame(-1, 0, 0, 1'b0, 1'b0, 0);

`ifdef DEMUX_SEQ_CH_MASK_EN
    do_start(16'h8421);
    run_frame(-1, 0, 0, 1'b0, 1'b0, 0);
    do_start(16'h0000);
    repeat (6) begin
      do_start(16'($urandom_range(65535)));
      run_frame(-1, 0, 30, 1'b0, 1'b0, 0);
    end
`endif

    repeat (4) begin
      do_start('1);
      run_frame(-1, 0, 35, 1'($urandom_range(1)), 1'($urandom_range(1)), 0);
    end

    repeat (3) @(posedge CLK);
    chk("scoreboard_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
